// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, registered active-video and sync decodes,
// sync outputs delayed to line up with the mappers' registered colour, plus frame strobe/counter.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       blank_next;
    logic       hs_next;
    logic       vs_next;
    logic       frame_next;
    logic       hs_raw;
    logic       vs_raw;

    always_comb begin
        x_next = DrawX + 10'd1;
        y_next = DrawY;
        if (DrawX == H_LAST) begin
            x_next = '0;
            y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
    end

    // Decodes look at the next counter values so the registered flags line up with DrawX/DrawY.
    assign blank_next = (x_next < H_VIS) && (y_next < V_VIS);
    assign hs_next    = !((x_next >= HS_BEG) && (x_next < HS_END));
    assign vs_next    = !((y_next >= VS_BEG) && (y_next < VS_END));
    assign frame_next = (x_next == '0) && (y_next == '0);

    // Stage 0: counters and decodes
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            blank       <= blank_next;
            hs_raw      <= hs_next;
            vs_raw      <= vs_next;
            frame_start <= frame_next;
            if (frame_next) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Stage 1..SYNC_DELAY: sync delay line
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_p;
            logic [SYNC_DELAY-1:0] vs_p;

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_p <= '1;
                    vs_p <= '1;
                end else begin
                    hs_p[0] <= hs_raw;
                    vs_p[0] <= vs_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_p[i] <= hs_p[i-1];
                        vs_p[i] <= vs_p[i-1];
                    end
                end
            end

            assign hs = hs_p[SYNC_DELAY-1];
            assign vs = vs_p[SYNC_DELAY-1];
        end
    endgenerate

endmodule
